fu_wb_queue: RTL

Per-functional-unit writeback request queue sitting between one SIMD/SIMF execution unit and the register-file write arbiter. It buffers completed writeback payloads and drives the `queue_entry_valid` request line to the arbiter. It pops the head entry when the arbiter returns `queue_entry_serviced`. One instance exists per SIMD0-3 and SIMF0-3 port.

---
 rtl/rfa_pkg.sv | 26 ++
 rtl/fu_wb_queue_if.sv | 27 ++
 rtl/wb_ptr_ctr.sv | 17 +
 rtl/fu_wb_queue.sv | 93 +++++++++
 4 files changed

// File: rtl/rfa_pkg.sv
// Shared register-file-arbiter definitions: default queue geometry and the
// bit layout of a writeback payload, common to the per-FU writeback queues,
// the write arbiter and the register-file write mux.
package rfa_pkg;

  localparam int DEFAULT_DEPTH  = 4;
  localparam int DEFAULT_DATA_W = 128;

  // Writeback payload field layout, LSB first.
  localparam int WB_DATA_LSB   = 0;
  localparam int WB_DATA_W     = 64;
  localparam int WB_MASK_LSB   = WB_DATA_LSB + WB_DATA_W;
  localparam int WB_MASK_W     = 48;
  localparam int WB_WFID_LSB   = WB_MASK_LSB + WB_MASK_W;
  localparam int WB_WFID_W     = 6;
  localparam int WB_DEST_LSB   = WB_WFID_LSB + WB_WFID_W;
  localparam int WB_DEST_W     = 10;

  typedef struct packed {
    logic [WB_DEST_W-1:0] dest_reg;
    logic [WB_WFID_W-1:0] wf_id;
    logic [WB_MASK_W-1:0] exec_mask;
    logic [WB_DATA_W-1:0] data;
  } wb_payload_t;

endpackage

// File: rtl/fu_wb_queue_if.sv
// Handshake bundle between a functional unit, its writeback queue and the
// register-file write arbiter. The queue side uses the slave modport.
interface fu_wb_queue_if
  import rfa_pkg::*;
#(
  parameter int DEPTH  = DEFAULT_DEPTH,
  parameter int DATA_W = DEFAULT_DATA_W
);
  logic                       enq_valid;
  logic [DATA_W-1:0]          enq_data;
  logic                       enq_ready;
  logic                       queue_entry_valid;
  logic                       queue_entry_serviced;
  logic [DATA_W-1:0]          head_data;
  logic [$clog2(DEPTH+1)-1:0] count;
  logic [1:0]                 err_flags;

  modport master (
    output enq_valid, enq_data, queue_entry_serviced,
    input  enq_ready, queue_entry_valid, head_data, count, err_flags
  );

  modport slave (
    input  enq_valid, enq_data, queue_entry_serviced,
    output enq_ready, queue_entry_valid, head_data, count, err_flags
  );
endinterface

// File: rtl/wb_ptr_ctr.sv
// Wrapping pointer for the writeback queue; wraps naturally at 2**W.
module wb_ptr_ctr #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] ptr
);

  // Advance the pointer on each enabled edge; cleared by the active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) ptr <= '0;
    else if (inc) ptr <= ptr + 1'b1;
  end

endmodule

// File: rtl/fu_wb_queue.sv
// Per-functional-unit writeback request queue. Buffers completed writeback
// payloads and requests the register-file write arbiter while non-empty; the
// head entry is popped when the arbiter grants. All status outputs come from
// flops, so no input reaches an output combinationally.
// Optional feature: define FU_WB_QUEUE_ERR_EN to enable sticky error flags
// (grant-while-empty, enqueue-while-full) plus simulation assertions.
module fu_wb_queue
  import rfa_pkg::*;
#(
  parameter int DEPTH  = DEFAULT_DEPTH,
  parameter int DATA_W = DEFAULT_DATA_W
) (
  input logic          clk,
  input logic          rst,
  fu_wb_queue_if.slave bus
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PW-1:0]     rd_ptr;
  logic [PW-1:0]     wr_ptr;
  logic [CW-1:0]     count_q;
  logic [CW-1:0]     count_next;
  logic              valid_q;
  logic              ready_q;
  logic              push;
  logic              pop;

  // Handshakes qualified by the registered status so a full queue never
  // refills in the same cycle it is drained, and an empty one ignores grants.
  assign push = bus.enq_valid & ready_q;
  assign pop  = bus.queue_entry_serviced & valid_q;

  wb_ptr_ctr #(.W(PW)) u_wr_ptr (.clk(clk), .rst(rst), .inc(push), .ptr(wr_ptr));
  wb_ptr_ctr #(.W(PW)) u_rd_ptr (.clk(clk), .rst(rst), .inc(pop),  .ptr(rd_ptr));

  // Occupancy moves only when exactly one of push/pop happens.
  always_comb begin
    count_next = count_q;
    if (push && !pop)      count_next = count_q + 1'b1;
    else if (pop && !push) count_next = count_q - 1'b1;
  end

  // Occupancy and the request/ready flags derived from it, all registered.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q <= '0;
      valid_q <= 1'b0;
      ready_q <= 1'b1;
    end else begin
      count_q <= count_next;
      valid_q <= (count_next != '0);
      ready_q <= (count_next != FULL_CNT);
    end
  end

  // Payload storage; not reset, since entries are only read while valid.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= bus.enq_data;
  end

  assign bus.head_data         = mem[rd_ptr];
  assign bus.count             = count_q;
  assign bus.queue_entry_valid = valid_q;
  assign bus.enq_ready         = ready_q;

`ifdef FU_WB_QUEUE_ERR_EN
  logic [1:0] err_q;

  // Sticky protocol-violation flags, cleared only by reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err_q <= 2'b00;
    end else begin
      if (bus.queue_entry_serviced && !valid_q) err_q[0] <= 1'b1;
      if (bus.enq_valid && !ready_q)            err_q[1] <= 1'b1;
    end
  end

  assign bus.err_flags = err_q;

  a_grant_while_empty: assert property (@(posedge clk) disable iff (!rst)
    !(bus.queue_entry_serviced && !valid_q));
  a_enq_while_full: assert property (@(posedge clk) disable iff (!rst)
    !(bus.enq_valid && !ready_q));
`else
  assign bus.err_flags = 2'b00;
`endif

endmodule
